// File: rtl/feature_read_ctrl_pkg.sv
// Shared constants and types for the feature-map read path.
// Used by the feature FIFO, the read controller and the conv engine.
package feature_read_ctrl_pkg;

    localparam int IMG_W  = 27;
    localparam int IMG_H  = 27;
    localparam int DATA_W = 8;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/feature_read_ctrl_if.sv
// FIFO-side and conv-side stream signals of the feature read controller.
// master: the controller (pops the FIFO, drives the beat stream).
// slave : the environment (FIFO head word and downstream ready).
interface feature_read_ctrl_if;
    import feature_read_ctrl_pkg::*;

    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CW-1:0]     m_col;
    logic [RW-1:0]     m_row;
    logic              m_eol;
    logic              m_last;

    modport master (
        input  fifo_valid, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_col, m_row, m_eol, m_last
    );

    modport slave (
        output fifo_valid, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_col, m_row, m_eol, m_last
    );

endinterface

// File: rtl/feature_read_ctrl_raster_counter.sv
// Raster-order column/row counter. Column wraps at W-1 and bumps the row;
// the row wraps only after the last position of the frame.
module raster_counter #(
    parameter int W = 27,
    parameter int H = 27,
    localparam int CW = $clog2(W),
    localparam int RW = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          eol_o,
    output logic          last_o
);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    assign eol_o  = (col_q == CW'(W - 1));
    assign last_o = eol_o && (row_q == RW'(H - 1));
    assign col_o  = col_q;
    assign row_o  = row_q;

    // Advance one raster position per increment; clear takes priority.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (inc_i) begin
            if (eol_o) begin
                col_q <= '0;
                row_q <= last_o ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/feature_read_ctrl.sv
// Reads one full IMG_W x IMG_H frame from the FWFT feature FIFO into the
// conv datapath, tagging each beat with row/col, end-of-row and end-of-frame.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | popping FIFO and presenting beats downstream
//   FIN   | last beat accepted; done pulses for this one cycle
module feature_read_ctrl
    import feature_read_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    feature_read_ctrl_if.master bus
);

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic              all_popped_q;

    logic              m_valid_q;
    logic [DATA_W-1:0] m_data_q;
    logic [CW-1:0]     m_col_q;
    logic [RW-1:0]     m_row_q;
    logic              m_eol_q;
    logic              m_last_q;

    logic              load;
    logic              accept;
    logic              clr;
    logic [CW-1:0]     cnt_col;
    logic [RW-1:0]     cnt_row;
    logic              cnt_eol;
    logic              cnt_last;

    // A pop needs a head word, frame budget left, and room in the output
    // register (empty, or being drained this same cycle). Reset blocks pops
    // immediately so an abandoned frame never consumes another word.
    assign load   = !rst && (state_q == RUN) && bus.fifo_valid && !all_popped_q
                    && (!m_valid_q || bus.m_ready);
    assign accept = m_valid_q && bus.m_ready;
    assign clr    = (state_q == IDLE) && start_i;

    raster_counter #(
        .W (IMG_W),
        .H (IMG_H)
    ) u_raster (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .inc_i  (load),
        .col_o  (cnt_col),
        .row_o  (cnt_row),
        .eol_o  (cnt_eol),
        .last_o (cnt_last)
    );

    // Frame sequencing with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept && m_last_q) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output beat register: load on pop, drop valid when drained without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_col_q      <= '0;
            m_row_q      <= '0;
            m_eol_q      <= 1'b0;
            m_last_q     <= 1'b0;
            all_popped_q <= 1'b0;
        end else begin
            if (clr) begin
                all_popped_q <= 1'b0;
            end
            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= bus.fifo_data;
                m_col_q   <= cnt_col;
                m_row_q   <= cnt_row;
                m_eol_q   <= cnt_eol;
                m_last_q  <= cnt_last;
                if (cnt_last) begin
                    all_popped_q <= 1'b1;
                end
            end else if (accept) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd_en = load;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_col      = m_col_q;
    assign bus.m_row      = m_row_q;
    assign bus.m_eol      = m_eol_q;
    assign bus.m_last     = m_last_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_feature_read_ctrl.sv
// Bench for feature_read_ctrl: a FIFO model feeds random words, and every
// accepted beat is compared against its raster position in the frame.
module tb_feature_read_ctrl;
    import feature_read_ctrl_pkg::*;

    localparam int NB = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst;
    logic start_i;
    logic busy_o;
    logic done_o;

    feature_read_ctrl_if bus();

    feature_read_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] arr [NB];
    int head, beat_idx, beats_total, done_cnt, cyc;
    int last_acc_cyc, first_acc_cyc, first_rd_cyc, first_mv_cyc, start_cyc;
    int ready_mode, fifo_mode, gap_at, gap_left;
    bit in_gap, junk_mode, b2b_mode, fin_next, done_seen, pop_now;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void new_frame_model();
        for (int i = 0; i < NB; i++) arr[i] = 8'($urandom);
        head          = 0;
        beat_idx      = 0;
        first_acc_cyc = 0;
        first_rd_cyc  = 0;
        first_mv_cyc  = 0;
    endfunction

    task automatic drive();
        if (b2b_mode && done_seen) begin
            new_frame_model();
            b2b_mode = 1'b0;
            start_i  = 1'b1;
        end else if (junk_mode && (fin_next || (beat_idx > 0 && beat_idx < NB && $urandom_range(7) == 0))) begin
            start_i = 1'b1;
        end else begin
            start_i = 1'b0;
        end
        case (ready_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ~bus.m_ready;
            default: bus.m_ready = ($urandom_range(2) != 0);
        endcase
        if (gap_at >= 0 && head == gap_at && gap_left > 0) begin
            in_gap         = 1'b1;
            gap_left       = gap_left - 1;
            bus.fifo_valid = 1'b0;
        end else begin
            in_gap         = 1'b0;
            bus.fifo_valid = (fifo_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
        end
        bus.fifo_data = arr[(head < NB) ? head : NB - 1];
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        fin_next  = 1'b0;
        done_seen = 1'b0;
        if (!rst) begin
            if (bus.m_valid && !bus.m_ready) chk("rd_en_stall", 32'(bus.fifo_rd_en), 0);
            if (bus.fifo_rd_en && first_rd_cyc == 0) first_rd_cyc = cyc;
            if (bus.m_valid && first_mv_cyc == 0) first_mv_cyc = cyc;
            if (in_gap && gap_left <= 8) chk("gap_mvalid", 32'(bus.m_valid), 0);
            if (bus.m_valid && bus.m_ready) begin
                if (beat_idx >= NB) begin
                    chk("extra_beat", beat_idx, NB - 1);
                end else begin
                    chk("data", 32'(bus.m_data), 32'(arr[beat_idx]));
                    chk("col",  32'(bus.m_col),  beat_idx % IMG_W);
                    chk("row",  32'(bus.m_row),  beat_idx / IMG_W);
                    chk("eol",  32'(bus.m_eol),  32'((beat_idx % IMG_W) == IMG_W - 1));
                    chk("last", 32'(bus.m_last), 32'(beat_idx == NB - 1));
                end
                fin_next = (beat_idx == NB - 1);
                if (first_acc_cyc == 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                beat_idx++;
                beats_total++;
            end
            if (done_o) begin
                chk("done_delay", cyc - last_acc_cyc, 1);
                done_cnt++;
                done_seen = 1'b1;
            end
        end
        pop_now = bus.fifo_rd_en && !rst;
        @(posedge clk);
        #1;
        if (pop_now) head++;
        drive();
    endtask

    task automatic start_frame();
        new_frame_model();
        start_cyc     = cyc + 1;
        start_i       = 1'b1;
        bus.fifo_data = arr[0];
        tick();
    endtask

    task automatic wait_done(int target, int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("done_reached", done_cnt, target);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_m_valid"}, 32'(bus.m_valid),    0);
        chk({tag, "_rd_en"},   32'(bus.fifo_rd_en), 0);
        chk({tag, "_busy"},    32'(busy_o),         0);
        chk({tag, "_done"},    32'(done_o),         0);
        chk({tag, "_data"},    32'(bus.m_data),     0);
        chk({tag, "_col"},     32'(bus.m_col),      0);
        chk({tag, "_row"},     32'(bus.m_row),      0);
        chk({tag, "_eol"},     32'(bus.m_eol),      0);
        chk({tag, "_last"},    32'(bus.m_last),     0);
    endtask

    initial begin
        int d0, b0, n;
        rst = 1'b1; start_i = 1'b0;
        bus.fifo_valid = 1'b1; bus.fifo_data = '0; bus.m_ready = 1'b0;
        head = 0; beat_idx = 0; beats_total = 0; done_cnt = 0; cyc = 0;
        last_acc_cyc = 0; first_acc_cyc = 0; first_rd_cyc = 0; first_mv_cyc = 0;
        ready_mode = 0; fifo_mode = 0; gap_at = -1; gap_left = 0;
        in_gap = 0; junk_mode = 0; b2b_mode = 0; fin_next = 0; done_seen = 0;
        for (int i = 0; i < NB; i++) arr[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        drive();
        repeat (3) tick();

        // 1: full throughput
        d0 = done_cnt; b0 = beats_total;
        start_frame();
        wait_done(d0 + 1, 3000);
        chk("t1_beats", beats_total - b0, NB);
        chk("t1_first_rd", first_rd_cyc, start_cyc + 1);
        chk("t1_first_mv", first_mv_cyc, start_cyc + 2);
        chk("t1_span", last_acc_cyc - first_acc_cyc, NB - 1);
        repeat (3) tick();

        // 2: ready toggling every cycle
        ready_mode = 1;
        d0 = done_cnt; b0 = beats_total;
        start_frame();
        wait_done(d0 + 1, 4000);
        chk("t2_beats", beats_total - b0, NB);
        repeat (3) tick();

        // 3: FIFO runs dry for 10 cycles before beat 100
        ready_mode = 0; gap_at = 100; gap_left = 10;
        d0 = done_cnt; b0 = beats_total;
        start_frame();
        wait_done(d0 + 1, 3000);
        chk("t3_beats", beats_total - b0, NB);
        chk("t3_gap_used", gap_left, 0);
        gap_at = -1;
        repeat (3) tick();

        // 4: stray start pulses in RUN and FIN
        ready_mode = 2; fifo_mode = 1; junk_mode = 1;
        d0 = done_cnt; b0 = beats_total;
        start_frame();
        wait_done(d0 + 1, 5000);
        junk_mode = 0;
        repeat (30) tick();
        chk("t4_one_done", done_cnt - d0, 1);
        chk("t4_beats", beats_total - b0, NB);
        chk("t4_idle", 32'(busy_o), 0);

        // 5: reset mid-frame, then a fresh frame
        start_frame();
        n = 0;
        while (beat_idx < 400 && n < 4000) begin
            tick();
            n++;
        end
        chk("t5_reached_400", 32'(beat_idx >= 400), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("t5_after_rst");
        b0 = beats_total;
        repeat (5) tick();
        chk("t5_quiet", beats_total - b0, 0);
        chk("t5_no_busy", 32'(busy_o), 0);
        d0 = done_cnt;
        start_frame();
        wait_done(d0 + 1, 5000);
        chk("t5_beats", beats_total - b0, NB);

        // 6: back-to-back frames
        repeat (3) tick();
        b2b_mode = 1;
        d0 = done_cnt; b0 = beats_total;
        start_frame();
        wait_done(d0 + 2, 10000);
        chk("t6_beats", beats_total - b0, 2 * NB);
        repeat (10) tick();
        chk("t6_dones", done_cnt - d0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
